// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and mid-bit sample points.
// Used by uart_rx16 and the matching uart_tx16.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } uart_state_e;

  localparam logic [3:0] MID_START = 4'd7;
  localparam logic [3:0] MID_BIT   = 4'd15;

  function automatic logic [3:0] midStart(int os);
    return 4'(os / 2 - 1);
  endfunction

endpackage

// File: rtl/uart_rx16_if.sv
// Byte handshake between uart_rx16 and its consumer.
// master drives data/valid, slave drives ready.
interface uart_rx16_if #(
  parameter int DATA_BITS = 8
);

  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;

  modport master (
    output rx_data,
    output rx_valid,
    input  rx_ready
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    output rx_ready
  );

endinterface

// File: rtl/rx_sync.sv
// Flop-chain synchroniser with configurable reset value
// plus a one-cycle rising-edge detect on the synchronised level.
module rx_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise
);

  logic [STAGES-1:0] ff;
  logic              prev;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ff   <= {STAGES{RST_VAL}};
      prev <= RST_VAL;
    end else begin
      ff   <= {ff[STAGES-2:0], d};
      prev <= ff[STAGES-1];
    end
  end

  assign q    = ff[STAGES-1];
  assign rise = q & ~prev;

endmodule

// File: rtl/uart_rx16.sv
// 16x-oversampling UART receiver, valid/ready byte output.
// Define UART_RX_PARITY_EN to add a parity bit (par_odd, parity_err).
module uart_rx16
  import uart_pkg::*;
#(
  parameter int DATA_BITS   = 8,
  parameter int OVERSAMPLE  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic baud16,
  input  logic rxd,
`ifdef UART_RX_PARITY_EN
  input  logic par_odd,
  output logic parity_err,
`endif
  uart_rx16_if.master rx,
  output logic frame_err,
  output logic overrun,
  output logic busy
);

  localparam logic [3:0] SMID  = midStart(OVERSAMPLE);
  localparam logic [3:0] SLAST = 4'(OVERSAMPLE - 1);
  localparam logic [2:0] BLAST = 3'(DATA_BITS - 1);

  uart_state_e          state;
  logic [3:0]           scnt;
  logic [2:0]           bcnt;
  logic [DATA_BITS-1:0] shift;
  logic                 tick;
  logic                 rxdS;
  logic                 step;
  logic                 stopAt;
  logic                 doLoad;
  logic                 hs;
  logic                 unusedBaudLvl;
  logic                 unusedRxdRise;

  rx_sync #(
    .STAGES  (SYNC_STAGES),
    .RST_VAL (1'b1)
  ) uBaudSync (
    .clk  (clk),
    .rst  (rst),
    .d    (baud16),
    .q    (unusedBaudLvl),
    .rise (tick)
  );

  rx_sync #(
    .STAGES  (SYNC_STAGES),
    .RST_VAL (1'b1)
  ) uRxdSync (
    .clk  (clk),
    .rst  (rst),
    .d    (rxd),
    .q    (rxdS),
    .rise (unusedRxdRise)
  );

  assign step   = tick & en;
  assign stopAt = step & (state == STOP) & (scnt == SLAST);
  assign doLoad = stopAt & rxdS;
  assign hs     = rx.rx_valid & rx.rx_ready;
  assign busy   = (state != IDLE);

`ifdef UART_RX_PARITY_EN
  logic parBit;
  logic parMis;

  assign parMis = ((^shift) ^ parBit) != par_odd;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      parity_err <= 1'b0;
    end else begin
      parity_err <= doLoad & parMis;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      scnt      <= '0;
      bcnt      <= '0;
      shift     <= '0;
      frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parBit    <= 1'b0;
`endif
    end else begin
      frame_err <= stopAt & ~rxdS;
      if (step) begin
        unique case (state)
          IDLE: begin
            if (!rxdS) begin
              state <= START;
              scnt  <= '0;
            end
          end
          START: begin
            if (scnt == SMID) begin
              scnt  <= '0;
              bcnt  <= '0;
              state <= rxdS ? IDLE : DATA;
            end else begin
              scnt <= scnt + 4'd1;
            end
          end
          DATA: begin
            if (scnt == SLAST) begin
              scnt  <= '0;
              shift <= {rxdS, shift[DATA_BITS-1:1]};
              bcnt  <= bcnt + 3'd1;
              if (bcnt == BLAST) begin
                bcnt  <= '0;
`ifdef UART_RX_PARITY_EN
                state <= PARITY;
`else
                state <= STOP;
`endif
              end
            end else begin
              scnt <= scnt + 4'd1;
            end
          end
`ifdef UART_RX_PARITY_EN
          PARITY: begin
            if (scnt == SLAST) begin
              scnt   <= '0;
              parBit <= rxdS;
              state  <= STOP;
            end else begin
              scnt <= scnt + 4'd1;
            end
          end
`endif
          STOP: begin
            if (scnt == SLAST) begin
              scnt  <= '0;
              state <= rxdS ? IDLE : BREAK;
            end else begin
              scnt <= scnt + 4'd1;
            end
          end
          BREAK: begin
            if (rxdS) state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // A completed byte never overwrites one the consumer has not taken.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx.rx_data  <= '0;
      rx.rx_valid <= 1'b0;
      overrun     <= 1'b0;
    end else if (doLoad) begin
      if (rx.rx_valid && !rx.rx_ready) begin
        overrun <= 1'b1;
      end else begin
        rx.rx_data  <= shift;
        rx.rx_valid <= 1'b1;
        overrun     <= 1'b0;
      end
    end else if (hs) begin
      rx.rx_valid <= 1'b0;
      overrun     <= 1'b0;
    end
  end

endmodule
